// File: rtl/riscv_if_queue.sv
`default_nettype none
// riscv_if_queue: instruction-fetch stage with a per-PC bimodal BHT and a
// decoupling fetch queue between the aligner/decompressor and decode.
module riscv_if_queue #(
  parameter int          QDEPTH      = 4,
  parameter int          BHT_ENTRIES = 64,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      fe_valid,
  input  logic [31:0]               fe_inst,
  input  logic                      fe_compressed,
  output logic                      fe_ready,
  output logic [31:0]               fetch_pc,
  input  logic                      redir_valid,
  input  logic [31:0]               redir_pc,
  input  logic                      upd_valid,
  input  logic [31:0]               upd_pc,
  input  logic                      upd_taken,
  output logic                      id_valid,
  input  logic                      id_ready,
  output logic [31:0]               id_inst,
  output logic [31:0]               id_pc,
  output logic                      id_compressed,
  output logic                      id_pred_taken,
  output logic [$clog2(QDEPTH):0]   q_count
);

  localparam int            PTRW      = $clog2(QDEPTH);
  localparam int            IDXW      = $clog2(BHT_ENTRIES);
  localparam logic [PTRW:0] FULL      = (PTRW + 1)'(QDEPTH);
  localparam logic [31:0]   NOP       = 32'h00000013;
  localparam logic [6:0]    OP_BRANCH = 7'b1100011;
  localparam logic [6:0]    OP_JAL    = 7'b1101111;

  logic [31:0]     inst_q [QDEPTH];
  logic [31:0]     pc_q   [QDEPTH];
  logic            comp_q [QDEPTH];
  logic            pred_q [QDEPTH];
  logic [PTRW-1:0] wr_ptr;
  logic [PTRW-1:0] rd_ptr;
  logic [1:0]      bht    [BHT_ENTRIES];

  logic            fe_fire;
  logic            id_fire;
  logic            is_branch;
  logic            is_jal;
  logic            pred_taken;
  logic [IDXW-1:0] look_idx;
  logic [IDXW-1:0] upd_idx;
  logic [31:0]     b_imm;
  logic [31:0]     j_imm;
  logic [31:0]     next_pc;
  logic            unused_upd_bits;

  // Handshakes look only at registered occupancy and the redirect.
  assign fe_ready = (q_count != FULL) & ~redir_valid;
  assign id_valid = (q_count != '0) & ~redir_valid;
  assign fe_fire  = fe_valid & fe_ready;
  assign id_fire  = id_valid & id_ready;

  assign look_idx        = fetch_pc[IDXW:1];
  assign upd_idx         = upd_pc[IDXW:1];
  assign unused_upd_bits = ^{upd_pc[31:IDXW+1], upd_pc[0]};

  assign is_branch  = (fe_inst[6:0] == OP_BRANCH);
  assign is_jal     = (fe_inst[6:0] == OP_JAL);
  assign pred_taken = is_jal | (is_branch & bht[look_idx][1]);

  assign b_imm = {{20{fe_inst[31]}}, fe_inst[7], fe_inst[30:25], fe_inst[11:8], 1'b0};
  assign j_imm = {{12{fe_inst[31]}}, fe_inst[19:12], fe_inst[20], fe_inst[30:21], 1'b0};

  always_comb begin
    next_pc = fetch_pc;
    if (redir_valid) begin
      next_pc = redir_pc;
    end else if (fe_fire) begin
      if (is_branch && pred_taken) begin
        next_pc = fetch_pc + b_imm;
      end else if (is_jal) begin
        next_pc = fetch_pc + j_imm;
      end else begin
        next_pc = fetch_pc + (fe_compressed ? 32'd2 : 32'd4);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      q_count  <= '0;
    end else begin
      fetch_pc <= next_pc;
      if (redir_valid) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        q_count <= '0;
      end else begin
        if (fe_fire) wr_ptr <= wr_ptr + PTRW'(1);
        if (id_fire) rd_ptr <= rd_ptr + PTRW'(1);
        case ({fe_fire, id_fire})
          2'b10:   q_count <= q_count + (PTRW + 1)'(1);
          2'b01:   q_count <= q_count - (PTRW + 1)'(1);
          default: q_count <= q_count;
        endcase
      end
    end
  end

  // Slot contents need no reset: occupancy gates every read.
  always_ff @(posedge clk) begin
    if (fe_fire) begin
      inst_q[wr_ptr] <= fe_inst;
      pc_q[wr_ptr]   <= fetch_pc;
      comp_q[wr_ptr] <= fe_compressed;
      pred_q[wr_ptr] <= pred_taken;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'b01;
    end else if (upd_valid) begin
      if (upd_taken && bht[upd_idx] != 2'b11) begin
        bht[upd_idx] <= bht[upd_idx] + 2'b01;
      end else if (!upd_taken && bht[upd_idx] != 2'b00) begin
        bht[upd_idx] <= bht[upd_idx] - 2'b01;
      end
    end
  end

  assign id_inst       = id_valid ? inst_q[rd_ptr] : NOP;
  assign id_pc         = id_valid ? pc_q[rd_ptr]   : 32'h0;
  assign id_compressed = id_valid & comp_q[rd_ptr];
  assign id_pred_taken = id_valid & pred_q[rd_ptr];

endmodule
`default_nettype wire

// File: tb/tb_riscv_if_queue.sv
`default_nettype none
// Directed self-checking bench for riscv_if_queue (default parameters).
module tb_riscv_if_queue;

  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [31:0] BR  = 32'h02000063;  // beq x0,x0,+0x20
  localparam logic [31:0] JAL = 32'hF81FF06F;  // jal x0,-0x80

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fe_valid = 1'b0;
  logic [31:0] fe_inst = NOP;
  logic        fe_compressed = 1'b0;
  logic        fe_ready;
  logic [31:0] fetch_pc;
  logic        redir_valid = 1'b0;
  logic [31:0] redir_pc = 32'h0;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = 32'h0;
  logic        upd_taken = 1'b0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic        id_compressed;
  logic        id_pred_taken;
  logic [2:0]  q_count;

  int n_chk  = 0;
  int n_pass = 0;

  riscv_if_queue #(.QDEPTH(4), .BHT_ENTRIES(64), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst),
    .fe_valid(fe_valid), .fe_inst(fe_inst), .fe_compressed(fe_compressed),
    .fe_ready(fe_ready), .fetch_pc(fetch_pc),
    .redir_valid(redir_valid), .redir_pc(redir_pc),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .id_valid(id_valid), .id_ready(id_ready), .id_inst(id_inst), .id_pc(id_pc),
    .id_compressed(id_compressed), .id_pred_taken(id_pred_taken),
    .q_count(q_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [31:0] pc);
    redir_valid = 1'b1;
    redir_pc    = pc;
    step();
    redir_valid = 1'b0;
  endtask

  task automatic fetch_one(input logic [31:0] inst);
    fe_valid = 1'b1;
    fe_inst  = inst;
    step();
    fe_valid = 1'b0;
  endtask

  task automatic drain_one();
    id_ready = 1'b1;
    step();
    id_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (2) step();
    rst = 1'b0;
    #1;
    chk("rst_id_valid", id_valid, 0);
    chk("rst_id_inst", id_inst, NOP);
    chk("rst_id_pc", id_pc, 0);
    chk("rst_id_comp", id_compressed, 0);
    chk("rst_id_pred", id_pred_taken, 0);
    chk("rst_fe_ready", fe_ready, 1);
    chk("rst_q_count", q_count, 0);
    chk("rst_fetch_pc", fetch_pc, 0);

    // Fill the queue with 4-byte NOPs, decode stalled.
    fe_valid = 1'b1;
    fe_inst  = NOP;
    for (int k = 0; k < 4; k++) begin
      chk("fill_pc", fetch_pc, 32'(4 * k));
      step();
    end
    #1;
    chk("full_count", q_count, 4);
    chk("full_ready", fe_ready, 0);
    chk("full_pc", fetch_pc, 32'h10);
    chk("full_id_valid", id_valid, 1);
    step();
    chk("held_pc", fetch_pc, 32'h10);
    chk("held_count", q_count, 4);

    // One dequeue from full, then drain in order.
    fe_valid = 1'b0;
    id_ready = 1'b1;
    #1;
    chk("deq_head_pc", id_pc, 0);
    chk("deq_ready_nopath", fe_ready, 0);
    step();
    id_ready = 1'b0;
    #1;
    chk("deq_count", q_count, 3);
    chk("deq_fe_ready", fe_ready, 1);
    id_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      #1;
      chk("order_pc", id_pc, 32'(4 * k));
      step();
    end
    id_ready = 1'b0;
    #1;
    chk("empty_count", q_count, 0);
    chk("empty_valid", id_valid, 0);
    chk("empty_inst", id_inst, NOP);

    // Compressed stream; write pointer has wrapped back to slot 0.
    redirect(32'h100);
    fe_valid      = 1'b1;
    fe_inst       = NOP;
    fe_compressed = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("c_fetch_pc", fetch_pc, 32'h100 + 32'(2 * k));
      step();
    end
    fe_valid      = 1'b0;
    fe_compressed = 1'b0;
    #1;
    chk("c_count", q_count, 3);
    id_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("c_id_pc", id_pc, 32'h100 + 32'(2 * k));
      chk("c_id_comp", id_compressed, 1);
      step();
    end
    id_ready = 1'b0;

    // Branch at 0x40: weakly not taken after reset.
    redirect(32'h40);
    fetch_one(BR);
    #1;
    chk("br0_next_pc", fetch_pc, 32'h44);
    chk("br0_pred", id_pred_taken, 0);
    chk("br0_inst", id_inst, BR);
    drain_one();

    upd_valid = 1'b1;
    upd_pc    = 32'h40;
    upd_taken = 1'b1;
    repeat (2) step();
    upd_valid = 1'b0;
    redirect(32'h40);
    fetch_one(BR);
    #1;
    chk("br1_next_pc", fetch_pc, 32'h60);
    chk("br1_pred", id_pred_taken, 1);
    drain_one();

    // Two more taken (four total) saturate; one not-taken keeps it taken.
    upd_valid = 1'b1;
    repeat (2) step();
    upd_taken = 1'b0;
    step();
    upd_valid = 1'b0;
    redirect(32'h40);
    fetch_one(BR);
    #1;
    chk("sat_next_pc", fetch_pc, 32'h60);
    chk("sat_pred", id_pred_taken, 1);
    drain_one();

    // Same-cycle lookup sees the pre-update counter (2), then 1 afterwards.
    redirect(32'h40);
    upd_valid = 1'b1;
    upd_taken = 1'b0;
    fetch_one(BR);
    upd_valid = 1'b0;
    #1;
    chk("same_next_pc", fetch_pc, 32'h60);
    chk("same_pred", id_pred_taken, 1);
    drain_one();
    redirect(32'h40);
    fetch_one(BR);
    #1;
    chk("after_next_pc", fetch_pc, 32'h44);
    chk("after_pred", id_pred_taken, 0);
    drain_one();

    // JAL backwards to 0.
    redirect(32'h80);
    fetch_one(JAL);
    #1;
    chk("jal_next_pc", fetch_pc, 32'h0);
    chk("jal_pred", id_pred_taken, 1);
    chk("jal_id_pc", id_pc, 32'h80);
    drain_one();

    // Redirect with three queued entries and a concurrent fetch.
    fe_valid = 1'b1;
    fe_inst  = NOP;
    repeat (3) step();
    redir_valid = 1'b1;
    redir_pc    = 32'h200;
    #1;
    chk("redir_q3", q_count, 3);
    chk("redir_id_valid", id_valid, 0);
    chk("redir_fe_ready", fe_ready, 0);
    step();
    redir_valid = 1'b0;
    fe_valid    = 1'b0;
    #1;
    chk("redir_count", q_count, 0);
    chk("redir_pc", fetch_pc, 32'h200);
    chk("redir_empty", id_valid, 0);
    fetch_one(NOP);
    #1;
    chk("redir_first_valid", id_valid, 1);
    chk("redir_first_pc", id_pc, 32'h200);
    drain_one();

    // Mid-operation reset drops entries and restores counters.
    upd_valid = 1'b1;
    upd_pc    = 32'h40;
    upd_taken = 1'b1;
    fe_valid  = 1'b1;
    repeat (2) step();
    upd_valid = 1'b0;
    fe_valid  = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("mrst_count", q_count, 0);
    chk("mrst_pc", fetch_pc, 0);
    chk("mrst_valid", id_valid, 0);
    redirect(32'h40);
    fetch_one(BR);
    #1;
    chk("mrst_bht_pc", fetch_pc, 32'h44);
    drain_one();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
